diff_dec_framer: RTL

Receive-side counterpart of the team's differential encoder. It differentially decodes a serial bitstream: each decoded bit equals the current input XOR the previous accepted input.
It then searches the decoded stream for a sync word, deserialises fixed-length frames of words, and re-checks sync at every frame boundary using a flywheel miss counter.
It sits between the line/bit-recovery logic and the word-level consumer.

---
 rtl/diff_comm_pkg.sv | 22 ++
 rtl/diff_dec_bit.sv | 34 +++
 rtl/diff_dec_framer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/diff_comm_pkg.sv
// Shared definitions for the differential line coding blocks: framer state
// encoding, default sync/word geometry and a counter-width helper.
package diff_comm_pkg;

  localparam int unsigned SYNC_W_DEF      = 8;
  localparam logic [7:0]  SYNC_WORD_DEF   = 8'h47;
  localparam int unsigned WORD_W_DEF      = 8;
  localparam int unsigned FRAME_WORDS_DEF = 4;
  localparam int unsigned MAX_MISS_DEF    = 2;

  typedef enum logic [1:0] {
    HUNT       = 2'd0,
    LOCKED     = 2'd1,
    SYNC_CHECK = 2'd2
  } frm_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/diff_dec_bit.sv
// Differential bit decoder: decoded bit = current input XOR previous accepted
// input, with a registered copy and one-cycle valid pulse.
module diff_dec_bit (
  input  logic clock,
  input  logic reset,
  input  logic enable_i,
  input  logic in_valid_i,
  input  logic in_i,
  output logic accept_c_o,
  output logic dec_c_o,
  output logic bit_out_o,
  output logic bit_valid_o
);

  logic prev_q;

  assign accept_c_o = enable_i & in_valid_i;
  assign dec_c_o    = in_i ^ prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q      <= 1'b0;
      bit_out_o   <= 1'b0;
      bit_valid_o <= 1'b0;
    end else begin
      bit_valid_o <= accept_c_o;
      if (accept_c_o) begin
        prev_q    <= in_i;
        bit_out_o <= dec_c_o;
      end
    end
  end

endmodule

// File: rtl/diff_dec_framer.sv
// Differential decoder plus sync-word framer: hunts for the sync word,
// deserialises fixed-length frames and flywheels over isolated sync misses.
module diff_dec_framer
  import diff_comm_pkg::*;
#(
  parameter int unsigned       SYNC_W      = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = SYNC_W'(SYNC_WORD_DEF),
  parameter int unsigned       WORD_W      = WORD_W_DEF,
  parameter int unsigned       FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int unsigned       MAX_MISS    = MAX_MISS_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic              in,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              locked,
  output logic              sync_err
);

  localparam int unsigned BIT_CW  = cnt_w(WORD_W);
  localparam int unsigned WORD_CW = cnt_w(FRAME_WORDS + 1);
  localparam int unsigned MISS_CW = cnt_w(MAX_MISS + 1);
  localparam int unsigned SYNC_CW = cnt_w(SYNC_W);

  localparam logic [BIT_CW-1:0]  BIT_LAST   = BIT_CW'(WORD_W - 1);
  localparam logic [WORD_CW-1:0] FRAME_CNT  = WORD_CW'(FRAME_WORDS);
  localparam logic [MISS_CW-1:0] MISS_LIMIT = MISS_CW'(MAX_MISS);
  localparam logic [SYNC_CW-1:0] SYNC_LAST  = SYNC_CW'(SYNC_W - 1);

  logic accept_c;
  logic dec_c;

  diff_dec_bit u_bit (
    .clock       (clock),
    .reset       (reset),
    .enable_i    (enable),
    .in_valid_i  (in_valid),
    .in_i        (in),
    .accept_c_o  (accept_c),
    .dec_c_o     (dec_c),
    .bit_out_o   (bit_out),
    .bit_valid_o (bit_valid)
  );

  frm_state_e          state_q;
  logic [SYNC_W-2:0]   sync_sr_q;
  logic [WORD_W-2:0]   word_sr_q;
  logic [BIT_CW-1:0]   bit_cnt_q;
  logic [WORD_CW-1:0]  word_cnt_q;
  logic [MISS_CW-1:0]  miss_cnt_q;
  logic [SYNC_CW-1:0]  sync_cnt_q;
  logic [WORD_W-1:0]   word_out_q;
  logic                word_valid_q;
  logic                locked_q;
  logic                sync_err_q;

  // Shift registers keep only the older bits; the newest bit is the live decode.
  logic [SYNC_W-1:0]  sync_shift_c;
  logic [WORD_W-1:0]  word_shift_c;
  logic [WORD_CW-1:0] word_cnt_inc_c;
  logic [MISS_CW-1:0] miss_inc_c;

  assign sync_shift_c   = {sync_sr_q, dec_c};
  assign word_shift_c   = {word_sr_q, dec_c};
  assign word_cnt_inc_c = word_cnt_q + WORD_CW'(1);
  assign miss_inc_c     = miss_cnt_q + MISS_CW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      sync_sr_q    <= '0;
      word_sr_q    <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      miss_cnt_q   <= '0;
      sync_cnt_q   <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (accept_c) begin
        unique case (state_q)
          HUNT: begin
            sync_sr_q <= sync_shift_c[SYNC_W-2:0];
            if (sync_shift_c == SYNC_WORD) begin
              state_q    <= LOCKED;
              locked_q   <= 1'b1;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
              miss_cnt_q <= '0;
            end
          end
          LOCKED: begin
            word_sr_q <= word_shift_c[WORD_W-2:0];
            if (bit_cnt_q == BIT_LAST) begin
              word_out_q   <= word_shift_c;
              word_valid_q <= 1'b1;
              bit_cnt_q    <= '0;
              word_cnt_q   <= word_cnt_inc_c;
              if (word_cnt_inc_c == FRAME_CNT) begin
                state_q    <= SYNC_CHECK;
                sync_cnt_q <= '0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_CW'(1);
            end
          end
          SYNC_CHECK: begin
            sync_sr_q <= sync_shift_c[SYNC_W-2:0];
            if (sync_cnt_q == SYNC_LAST) begin
              sync_cnt_q <= '0;
              word_cnt_q <= '0;
              bit_cnt_q  <= '0;
              if (sync_shift_c == SYNC_WORD) begin
                miss_cnt_q <= '0;
                state_q    <= LOCKED;
              end else begin
                sync_err_q <= 1'b1;
                miss_cnt_q <= miss_inc_c;
                if (miss_inc_c == MISS_LIMIT) begin
                  // Lock lost: restart the sliding search from an empty window.
                  state_q   <= HUNT;
                  locked_q  <= 1'b0;
                  sync_sr_q <= '0;
                end else begin
                  state_q <= LOCKED;
                end
              end
            end else begin
              sync_cnt_q <= sync_cnt_q + SYNC_CW'(1);
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;

endmodule
